// File: rtl/mc_common_pkg.sv
// Shared BTB types and helpers: entry record, address split and counter saturation.
// Fields are sized for the widest legal configuration; narrower instances keep the upper bits at zero.
package mc_common_pkg;

  localparam int BTB_TAG_MAX = 30;
  localparam int BTB_CTR_MAX = 3;

  typedef struct packed {
    logic                   vld;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            tgt;
    logic [BTB_CTR_MAX-1:0] ctr;
  } btb_entry_t;

  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int idxw);
    return (pc >> 2) & ((32'd1 << idxw) - 32'd1);
  endfunction

  function automatic logic [BTB_TAG_MAX-1:0] btb_tag(input logic [31:0] pc, input int idxw,
                                                     input int tagw);
    logic [31:0] sh;
    sh = pc >> (idxw + 2);
    return BTB_TAG_MAX'(sh & ((32'd1 << tagw) - 32'd1));
  endfunction

  function automatic logic [BTB_CTR_MAX-1:0] ctr_sat(input logic [BTB_CTR_MAX-1:0] ctr,
                                                     input logic inc, input int ctrw);
    logic [BTB_CTR_MAX-1:0] mx;
    mx = BTB_CTR_MAX'((1 << ctrw) - 1);
    if (inc) return (ctr == mx) ? ctr : ctr + 1'b1;
    else     return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: next tree bits after a touch, and the current victim way.
// Node n has children 2n+1 (left) and 2n+2 (right); a 1 bit means the victim lies to the right.
module plru_tree #(
  parameter int WAYS = 4,
  localparam int BITW = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [BITW-1:0] bits_in,
  input  logic [WAYW-1:0] touch_way,
  input  logic            touch_en,
  output logic [BITW-1:0] bits_next,
  output logic [WAYW-1:0] victim
);

  if (WAYS == 1) begin : g_dm
    assign bits_next = '0;
    assign victim    = '0;
  end else begin : g_tree
    localparam int LVLS = $clog2(WAYS);

    always_comb begin
      int node;
      victim = '0;
      node   = 0;
      for (int l = 0; l < LVLS; l++) begin
        victim[WAYW'(LVLS-1-l)] = bits_in[LVLS'(node)];
        node = 2 * node + 1 + int'(bits_in[LVLS'(node)]);
      end
    end

    // Every node on the touched path is turned to point away from the touched way.
    always_comb begin
      int   node;
      logic dir;
      bits_next = bits_in;
      node      = 0;
      dir       = 1'b0;
      if (touch_en) begin
        for (int l = 0; l < LVLS; l++) begin
          dir = touch_way[WAYW'(LVLS-1-l)];
          bits_next[LVLS'(node)] = ~dir;
          node = 2 * node + 1 + int'(dir);
        end
      end
    end
  end

endmodule

// File: rtl/btb_sa.sv
// Set-associative branch target buffer: combinational lookup, clocked update from branch resolution,
// per-entry saturating direction counter and tree pseudo-LRU replacement.
module btb_sa
  import mc_common_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 4,
  parameter int TAGW = 20,
  parameter int CTRW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic [31:0] up_target
);

  localparam int IDXW  = $clog2(SETS);
  localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRUW = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [BTB_CTR_MAX-1:0] CTR_INIT = BTB_CTR_MAX'(1 << (CTRW - 1));

  btb_entry_t       entry_q [SETS][WAYS];
  btb_entry_t       entry_d;
  logic [PLRUW-1:0] plru_q  [SETS];
  logic [PLRUW-1:0] plru_d  [SETS];

  logic [IDXW-1:0]        lk_idx, up_idx;
  logic [BTB_TAG_MAX-1:0] lk_tag, up_tag;
  logic [WAYS-1:0]        lk_way_hit, up_way_hit, up_way_vld;
  logic [WAYW-1:0]        lk_hit_way, up_hit_way, inv_way, victim_way, up_touch_way;
  logic [WAYW-1:0]        plru_victim, lk_victim_unused;
  logic [PLRUW-1:0]       lk_plru_next, up_plru_next;
  logic                   any_inv, up_hit, up_touch_en, lk_touch;
  btb_entry_t             lk_entry;

  assign lk_idx = IDXW'(btb_idx(lk_pc, IDXW));
  assign up_idx = IDXW'(btb_idx(up_pc, IDXW));
  assign lk_tag = btb_tag(lk_pc, IDXW, TAGW);
  assign up_tag = btb_tag(up_pc, IDXW, TAGW);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign lk_way_hit[gi] = entry_q[lk_idx][gi].vld && (entry_q[lk_idx][gi].tag == lk_tag);
    assign up_way_hit[gi] = entry_q[up_idx][gi].vld && (entry_q[up_idx][gi].tag == up_tag);
    assign up_way_vld[gi] = entry_q[up_idx][gi].vld;
  end

  // Descending scan so the lowest-index way wins each encoder.
  always_comb begin
    lk_hit_way = '0;
    up_hit_way = '0;
    inv_way    = '0;
    any_inv    = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_way_hit[w]) lk_hit_way = WAYW'(w);
      if (up_way_hit[w]) up_hit_way = WAYW'(w);
      if (!up_way_vld[w]) begin
        inv_way = WAYW'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign lk_hit    = |lk_way_hit;
  assign lk_entry  = entry_q[lk_idx][lk_hit_way];
  assign lk_taken  = lk_hit & lk_entry.ctr[CTRW-1];
  assign lk_target = lk_hit ? lk_entry.tgt : '0;

  assign up_hit       = |up_way_hit;
  assign victim_way   = any_inv ? inv_way : plru_victim;
  assign up_touch_en  = up_valid & ~flush & (up_hit | up_taken);
  assign up_touch_way = up_hit ? up_hit_way : victim_way;

  plru_tree #(.WAYS(WAYS)) u_plru_up (
    .bits_in   (plru_q[up_idx]),
    .touch_way (up_touch_way),
    .touch_en  (up_touch_en),
    .bits_next (up_plru_next),
    .victim    (plru_victim)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_lk (
    .bits_in   (plru_q[lk_idx]),
    .touch_way (lk_hit_way),
    .touch_en  (lk_valid & lk_hit),
    .bits_next (lk_plru_next),
    .victim    (lk_victim_unused)
  );

  always_comb begin
    entry_d = entry_q[up_idx][up_hit_way];
    if (up_hit) begin
      entry_d.ctr = ctr_sat(entry_d.ctr, up_taken, CTRW);
      if (up_taken) entry_d.tgt = up_target;
    end else begin
      entry_d.vld = 1'b1;
      entry_d.tag = up_tag;
      entry_d.tgt = up_target;
      entry_d.ctr = CTR_INIT;
    end
  end

  // When both touches land in the same set, the update's touch takes precedence.
  always_comb begin
    for (int s = 0; s < SETS; s++) plru_d[s] = plru_q[s];
    lk_touch = lk_valid & lk_hit & ~(up_touch_en & (lk_idx == up_idx));
    if (lk_touch)    plru_d[lk_idx] = lk_plru_next;
    if (up_touch_en) plru_d[up_idx] = up_plru_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) entry_q[s][w] <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) entry_q[s][w].vld <= 1'b0;
      end
    end else begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= plru_d[s];
      if (up_touch_en) entry_q[up_idx][up_touch_way] <= entry_d;
    end
  end

endmodule

// File: tb/tb_btb_sa.sv
// Directed bench for btb_sa in a 4-set, 2-way, 8-bit tag, 2-bit counter configuration.
module tb_btb_sa;

  logic        clk = 1'b0;
  logic        rst, flush, lk_valid, up_valid, up_taken;
  logic [31:0] lk_pc, up_pc, up_target, lk_target;
  logic        lk_hit, lk_taken;
  int          checks = 0;
  int          errors = 0;

  always #20 clk = ~clk;

  btb_sa #(.SETS(4), .WAYS(2), .TAGW(8), .CTRW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .lk_valid  (lk_valid),
    .lk_pc     (lk_pc),
    .lk_hit    (lk_hit),
    .lk_taken  (lk_taken),
    .lk_target (lk_target),
    .up_valid  (up_valid),
    .up_pc     (up_pc),
    .up_taken  (up_taken),
    .up_target (up_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic hit, input logic taken,
                      input logic [31:0] tgt, input string tag);
    lk_pc = pc;
    #1;
    $display("lookup pc=%h hit=%0d taken=%0d target=%h", pc, lk_hit, lk_taken, lk_target);
    chk({tag, "_hit"}, 32'(lk_hit), 32'(hit));
    chk({tag, "_taken"}, 32'(lk_taken), 32'(taken));
    chk({tag, "_target"}, lk_target, tgt);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    up_valid  = 1'b1;
    up_pc     = pc;
    up_taken  = taken;
    up_target = tgt;
    $display("update pc=%h taken=%0d target=%h", pc, taken, tgt);
    tick();
    up_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_pc = '0;
    up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_target = '0;
    repeat (2) tick();
    rst = 1'b0;
    look(32'h100, 1'b0, 1'b0, 32'h0, "reset");

    // First allocation; same-cycle lookup sees pre-edge state
    up_valid = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h400;
    lk_pc = 32'h100;
    #1;
    chk("same_cycle_hit", 32'(lk_hit), 32'd0);
    tick();
    up_valid = 1'b0;
    look(32'h100, 1'b1, 1'b1, 32'h400, "alloc");

    // Counter: 2 -> 3 (saturate) then down to 0 (saturate) and back up
    do_update(32'h100, 1'b1, 32'h400);
    do_update(32'h100, 1'b1, 32'h400);
    do_update(32'h100, 1'b1, 32'h404);
    look(32'h100, 1'b1, 1'b1, 32'h404, "ctr3");
    do_update(32'h100, 1'b0, 32'hdead0000);
    look(32'h100, 1'b1, 1'b1, 32'h404, "dec_to2");
    do_update(32'h100, 1'b0, 32'hdead0000);
    look(32'h100, 1'b1, 1'b0, 32'h404, "dec_to1");
    do_update(32'h100, 1'b0, 32'hdead0000);
    look(32'h100, 1'b1, 1'b0, 32'h404, "dec_to0");
    do_update(32'h100, 1'b0, 32'hdead0000);
    do_update(32'h100, 1'b1, 32'h404);
    look(32'h100, 1'b1, 1'b0, 32'h404, "sat_low");
    do_update(32'h100, 1'b1, 32'h404);
    look(32'h100, 1'b1, 1'b1, 32'h404, "inc_to2");

    // Fill set 0, touch way0 by lookup, then allocation evicts way1
    do_update(32'h200, 1'b1, 32'h600);
    look(32'h200, 1'b1, 1'b1, 32'h600, "alloc_way1");
    lk_pc = 32'h100; lk_valid = 1'b1;
    tick();
    lk_valid = 1'b0;
    do_update(32'h300, 1'b1, 32'h700);
    look(32'h200, 1'b0, 1'b0, 32'h0, "evicted_200");
    look(32'h100, 1'b1, 1'b1, 32'h404, "kept_100");
    look(32'h300, 1'b1, 1'b1, 32'h700, "alloc_300");

    // Same-set lookup touch (way1) and update touch (way0): update wins, way1 is next victim
    lk_pc = 32'h300; lk_valid = 1'b1;
    up_valid = 1'b1; up_pc = 32'h100; up_taken = 1'b1; up_target = 32'h404;
    tick();
    lk_valid = 1'b0; up_valid = 1'b0;
    do_update(32'h200, 1'b1, 32'h600);
    look(32'h300, 1'b0, 1'b0, 32'h0, "upd_touch_wins");
    look(32'h100, 1'b1, 1'b1, 32'h404, "upd_touch_100");
    look(32'h200, 1'b1, 1'b1, 32'h600, "realloc_200");

    // Not-taken miss does not allocate
    do_update(32'h500, 1'b0, 32'h900);
    look(32'h500, 1'b0, 1'b0, 32'h0, "nt_miss");
    look(32'h200, 1'b1, 1'b1, 32'h600, "nt_keep_200");

    // Partial-tag alias, ignored low bits, other set empty
    look(32'h1100, 1'b1, 1'b1, 32'h404, "alias");
    look(32'h102, 1'b1, 1'b1, 32'h404, "low_bits");
    look(32'h104, 1'b0, 1'b0, 32'h0, "other_set");

    // Flush drops the simultaneous update
    flush = 1'b1;
    up_valid = 1'b1; up_pc = 32'h600; up_taken = 1'b1; up_target = 32'h800;
    tick();
    flush = 1'b0; up_valid = 1'b0;
    look(32'h100, 1'b0, 1'b0, 32'h0, "flush_100");
    look(32'h200, 1'b0, 1'b0, 32'h0, "flush_200");
    look(32'h600, 1'b0, 1'b0, 32'h0, "flush_600");
    do_update(32'h600, 1'b1, 32'h800);
    look(32'h600, 1'b1, 1'b1, 32'h800, "post_flush");

    // Reset overrides a concurrent update
    rst = 1'b1;
    up_valid = 1'b1; up_pc = 32'h200; up_taken = 1'b1; up_target = 32'h600;
    tick();
    rst = 1'b0; up_valid = 1'b0;
    look(32'h600, 1'b0, 1'b0, 32'h0, "rst_600");
    look(32'h200, 1'b0, 1'b0, 32'h0, "rst_200");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
